cpu_bus_responder: RTL and testbench



---
 rtl/cpu_bus_responder.sv | 177 +++++++++++++++++
 tb/tb_cpu_bus_responder.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_bus_responder.sv
// cpu_bus_responder: answers CPU bus requests from RAM, GPIO, vectors or ext port.
// Optional ext-port watchdog: define CPU_BUS_RESPONDER_WATCHDOG_EN.
module cpu_bus_responder #(
  parameter int          RAM_AW    = 11,
  parameter logic [15:0] GPIO_ADDR = 16'h4000,
  parameter logic [15:0] NMI_VEC   = 16'h0000,
  parameter logic [15:0] RST_VEC   = 16'h0200,
  parameter logic [15:0] IRQ_VEC   = 16'h0300,
  parameter int          TIMEOUT   = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  addr_hi,
  input  logic [7:0]  addr_lo,
  input  logic [7:0]  data_from_cpu,
  input  logic        rw,
  input  logic        bus_valid,
  output logic [7:0]  data_to_cpu,
  output logic        ready,
  output logic        bus_error,
  output logic [7:0]  gpio_out,
  output logic        ext_req,
  output logic        ext_we,
  output logic [15:0] ext_addr,
  output logic [7:0]  ext_wdata,
  input  logic [7:0]  ext_rdata,
  input  logic        ext_ack
);

  typedef enum logic [1:0] {
    IDLE, LOCAL, EXT_WAIT, DONE
  } state_t;

  typedef enum logic [1:0] {
    T_VEC, T_GPIO, T_RAM, T_EXT
  } tgt_t;

  state_t            state;
  tgt_t              tgt;
  tgt_t              dec;
  logic [15:0]       a;
  logic [RAM_AW-1:0] ram_idx;
  logic [2:0]        vsel;
  logic              cap_rw;
  logic [7:0]        cap_wdata;
  logic [7:0]        rdata;
  logic [7:0]        vbyte;
  logic [7:0]        mem [2**RAM_AW];

`ifdef CPU_BUS_RESPONDER_WATCHDOG_EN
  localparam logic [15:0] WD_LAST = 16'(TIMEOUT - 1);
  logic [15:0] wd_cnt;
  logic        tmo;
`else
  assign bus_error = 1'b0;
`endif

  assign a = {addr_hi, addr_lo};

  // Target decode, highest priority first
  always_comb begin
    if (a >= 16'hFFFA)
      dec = T_VEC;
    else if (a == GPIO_ADDR)
      dec = T_GPIO;
    else if ({1'b0, a} < 17'(2**RAM_AW))
      dec = T_RAM;
    else
      dec = T_EXT;
  end

  // Little-endian vector byte select
  always_comb begin
    case (vsel[2:1])
      2'b01:   vbyte = vsel[0] ? NMI_VEC[15:8] : NMI_VEC[7:0];
      2'b10:   vbyte = vsel[0] ? RST_VEC[15:8] : RST_VEC[7:0];
      2'b11:   vbyte = vsel[0] ? IRQ_VEC[15:8] : IRQ_VEC[7:0];
      default: vbyte = 8'h00;
    endcase
  end

  // RAM array write port; contents survive reset
  always_ff @(posedge clk) begin
    if (state == LOCAL && tgt == T_RAM && !cap_rw)
      mem[ram_idx] <= cap_wdata;
  end

  // Request FSM with registered bus and ext-port outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      tgt         <= T_VEC;
      ram_idx     <= '0;
      vsel        <= '0;
      cap_rw      <= 1'b0;
      cap_wdata   <= '0;
      rdata       <= '0;
      data_to_cpu <= '0;
      ready       <= 1'b0;
      gpio_out    <= '0;
      ext_req     <= 1'b0;
      ext_we      <= 1'b0;
      ext_addr    <= '0;
      ext_wdata   <= '0;
`ifdef CPU_BUS_RESPONDER_WATCHDOG_EN
      wd_cnt      <= '0;
      tmo         <= 1'b0;
      bus_error   <= 1'b0;
`endif
    end else begin
      ready <= 1'b0;
`ifdef CPU_BUS_RESPONDER_WATCHDOG_EN
      bus_error <= 1'b0;
`endif
      unique case (state)
        IDLE: begin
          if (bus_valid) begin
            tgt       <= dec;
            ram_idx   <= a[RAM_AW-1:0];
            vsel      <= a[2:0];
            cap_rw    <= rw;
            cap_wdata <= data_from_cpu;
            if (dec == T_EXT) begin
              ext_req   <= 1'b1;
              ext_we    <= ~rw;
              ext_addr  <= a;
              ext_wdata <= data_from_cpu;
`ifdef CPU_BUS_RESPONDER_WATCHDOG_EN
              wd_cnt    <= '0;
`endif
              state     <= EXT_WAIT;
            end else begin
              state <= LOCAL;
            end
          end
        end
        LOCAL: begin
          case (tgt)
            T_RAM:   if (cap_rw) rdata <= mem[ram_idx];
            T_GPIO:  if (cap_rw) rdata <= gpio_out;
                     else gpio_out <= cap_wdata;
            T_VEC:   if (cap_rw) rdata <= vbyte;
            default: ;
          endcase
          state <= DONE;
        end
        EXT_WAIT: begin
          if (ext_ack) begin
            if (cap_rw) rdata <= ext_rdata;
            ext_req <= 1'b0;
            state   <= DONE;
          end
`ifdef CPU_BUS_RESPONDER_WATCHDOG_EN
          else if (wd_cnt == WD_LAST) begin
            rdata   <= 8'hFF;
            tmo     <= 1'b1;
            ext_req <= 1'b0;
            state   <= DONE;
          end else begin
            wd_cnt <= wd_cnt + 16'd1;
          end
`endif
        end
        DONE: begin
          ready       <= 1'b1;
          data_to_cpu <= rdata;
`ifdef CPU_BUS_RESPONDER_WATCHDOG_EN
          bus_error   <= tmo;
          tmo         <= 1'b0;
`endif
          state       <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_bus_responder.sv
// tb_cpu_bus_responder: directed checks of the CPU bus responder.
// Watchdog steps run when CPU_BUS_RESPONDER_WATCHDOG_EN is defined.
module tb_cpu_bus_responder;

  logic        clk;
  logic        rst;
  logic [7:0]  addr_hi;
  logic [7:0]  addr_lo;
  logic [7:0]  data_from_cpu;
  logic        rw;
  logic        bus_valid;
  logic [7:0]  data_to_cpu;
  logic        ready;
  logic        bus_error;
  logic [7:0]  gpio_out;
  logic        ext_req;
  logic        ext_we;
  logic [15:0] ext_addr;
  logic [7:0]  ext_wdata;
  logic [7:0]  ext_rdata;
  logic        ext_ack;

  int errors = 0;
  int checks = 0;

  cpu_bus_responder dut (
    .clk           (clk),
    .rst           (rst),
    .addr_hi       (addr_hi),
    .addr_lo       (addr_lo),
    .data_from_cpu (data_from_cpu),
    .rw            (rw),
    .bus_valid     (bus_valid),
    .data_to_cpu   (data_to_cpu),
    .ready         (ready),
    .bus_error     (bus_error),
    .gpio_out      (gpio_out),
    .ext_req       (ext_req),
    .ext_we        (ext_we),
    .ext_addr      (ext_addr),
    .ext_wdata     (ext_wdata),
    .ext_rdata     (ext_rdata),
    .ext_ack       (ext_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [15:0] obs,
                     input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one request; it is accepted at the next edge.
  task automatic issue(input logic [15:0] ad,
                       input logic [7:0] wd,
                       input logic r);
    addr_hi       = ad[15:8];
    addr_lo       = ad[7:0];
    data_from_cpu = wd;
    rw            = r;
    bus_valid     = 1'b1;
    tick();
    bus_valid = 1'b0;
  endtask

  // Local access: ready must rise exactly two edges after acceptance.
  task automatic local_txn(input string tag,
                           input logic [15:0] ad,
                           input logic [7:0] wd,
                           input logic r,
                           input logic [7:0] exp_rd);
    issue(ad, wd, r);
    tick();
    chk({tag, ".rdy_early"}, 16'(ready), 16'h0);
    tick();
    chk({tag, ".rdy"}, 16'(ready), 16'h1);
    if (r) chk({tag, ".data"}, 16'(data_to_cpu), 16'(exp_rd));
    tick();
    chk({tag, ".rdy_off"}, 16'(ready), 16'h0);
  endtask

  initial begin
    rst = 1'b1;
    addr_hi = 8'h00;
    addr_lo = 8'h00;
    data_from_cpu = 8'h00;
    rw = 1'b1;
    bus_valid = 1'b0;
    ext_rdata = 8'h00;
    ext_ack = 1'b0;
    #1;
    chk("rst.ready", 16'(ready), 16'h0);
    chk("rst.bus_error", 16'(bus_error), 16'h0);
    chk("rst.gpio", 16'(gpio_out), 16'h0);
    chk("rst.ext_req", 16'(ext_req), 16'h0);
    chk("rst.ext_we", 16'(ext_we), 16'h0);
    chk("rst.ext_addr", ext_addr, 16'h0);
    chk("rst.ext_wdata", 16'(ext_wdata), 16'h0);
    chk("rst.data", 16'(data_to_cpu), 16'h0);
    tick();
    tick();
    rst = 1'b0;
    tick();

    // RAM
    local_txn("ram.w123", 16'h0123, 8'h5A, 1'b0, 8'h00);
    local_txn("ram.r123", 16'h0123, 8'h00, 1'b1, 8'h5A);
    local_txn("ram.w7ff", 16'h07FF, 8'h3C, 1'b0, 8'h00);
    local_txn("ram.r7ff", 16'h07FF, 8'h00, 1'b1, 8'h3C);
    local_txn("ram.r123b", 16'h0123, 8'h00, 1'b1, 8'h5A);

    // GPIO
    local_txn("gpio.w", 16'h4000, 8'hA5, 1'b0, 8'h00);
    chk("gpio.out", 16'(gpio_out), 16'h00A5);
    local_txn("gpio.r", 16'h4000, 8'h00, 1'b1, 8'hA5);

    // Vectors
    local_txn("vec.fffc", 16'hFFFC, 8'h00, 1'b1, 8'h00);
    local_txn("vec.fffd", 16'hFFFD, 8'h00, 1'b1, 8'h02);
    local_txn("vec.fffa", 16'hFFFA, 8'h00, 1'b1, 8'h00);
    local_txn("vec.ffff", 16'hFFFF, 8'h00, 1'b1, 8'h03);
    local_txn("vec.wfffc", 16'hFFFC, 8'h11, 1'b0, 8'h00);
    local_txn("vec.fffc2", 16'hFFFC, 8'h00, 1'b1, 8'h00);
    chk("vec.gpio_kept", 16'(gpio_out), 16'h00A5);

    // External read, ack sampled at the fifth edge after acceptance
    issue(16'h8000, 8'h00, 1'b1);
    chk("extr.req", 16'(ext_req), 16'h1);
    chk("extr.addr", ext_addr, 16'h8000);
    chk("extr.we", 16'(ext_we), 16'h0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("extr.req_hold", 16'(ext_req), 16'h1);
      chk("extr.no_rdy", 16'(ready), 16'h0);
    end
    ext_ack = 1'b1;
    ext_rdata = 8'h77;
    tick();
    ext_ack = 1'b0;
    ext_rdata = 8'h00;
    chk("extr.req_drop", 16'(ext_req), 16'h0);
    chk("extr.rdy_early", 16'(ready), 16'h0);
    tick();
    chk("extr.rdy", 16'(ready), 16'h1);
    chk("extr.data", 16'(data_to_cpu), 16'h0077);
    tick();
    chk("extr.rdy_off", 16'(ready), 16'h0);

    // External write with a competing request during the wait
    issue(16'h9001, 8'h99, 1'b0);
    chk("extw.we", 16'(ext_we), 16'h1);
    chk("extw.wdata", 16'(ext_wdata), 16'h0099);
    chk("extw.addr", ext_addr, 16'h9001);
    addr_hi = 8'h40;
    addr_lo = 8'h00;
    data_from_cpu = 8'h12;
    rw = 1'b0;
    bus_valid = 1'b1;
    tick();
    tick();
    bus_valid = 1'b0;
    chk("extw.addr_held", ext_addr, 16'h9001);
    chk("extw.wdata_held", 16'(ext_wdata), 16'h0099);
    chk("extw.req_held", 16'(ext_req), 16'h1);
    ext_ack = 1'b1;
    tick();
    ext_ack = 1'b0;
    chk("extw.req_drop", 16'(ext_req), 16'h0);
    tick();
    chk("extw.rdy", 16'(ready), 16'h1);
    chk("extw.gpio_untouched", 16'(gpio_out), 16'h00A5);
    ext_ack = 1'b1;
    tick();
    ext_ack = 1'b0;
    chk("spur.rdy", 16'(ready), 16'h0);
    chk("spur.req", 16'(ext_req), 16'h0);
    tick();
    chk("spur.rdy2", 16'(ready), 16'h0);
    tick();
    chk("spur.rdy3", 16'(ready), 16'h0);

    // Reset in the middle of an external wait
    issue(16'hA000, 8'h00, 1'b1);
    tick();
    chk("arst.req_before", 16'(ext_req), 16'h1);
    #2;
    rst = 1'b1;
    #1;
    chk("arst.req", 16'(ext_req), 16'h0);
    chk("arst.ready", 16'(ready), 16'h0);
    chk("arst.gpio", 16'(gpio_out), 16'h0);
    tick();
    rst = 1'b0;
    ext_ack = 1'b1;
    tick();
    ext_ack = 1'b0;
    chk("arst.no_rdy1", 16'(ready), 16'h0);
    tick();
    chk("arst.no_rdy2", 16'(ready), 16'h0);
    chk("arst.no_req", 16'(ext_req), 16'h0);
    local_txn("arst.ram", 16'h0123, 8'h00, 1'b1, 8'h5A);

`ifdef CPU_BUS_RESPONDER_WATCHDOG_EN
    issue(16'hB000, 8'h00, 1'b1);
    for (int i = 0; i < 15; i++) begin
      tick();
      chk("wd.req_hold", 16'(ext_req), 16'h1);
      chk("wd.no_err", 16'(bus_error), 16'h0);
    end
    tick();
    chk("wd.req_drop", 16'(ext_req), 16'h0);
    chk("wd.rdy_early", 16'(ready), 16'h0);
    tick();
    chk("wd.rdy", 16'(ready), 16'h1);
    chk("wd.err", 16'(bus_error), 16'h1);
    chk("wd.data", 16'(data_to_cpu), 16'h00FF);
    tick();
    chk("wd.err_off", 16'(bus_error), 16'h0);
    chk("wd.rdy_off", 16'(ready), 16'h0);

    issue(16'hB001, 8'h00, 1'b1);
    for (int i = 0; i < 15; i++) tick();
    chk("wdack.req_hold", 16'(ext_req), 16'h1);
    ext_ack = 1'b1;
    ext_rdata = 8'h42;
    tick();
    ext_ack = 1'b0;
    tick();
    chk("wdack.rdy", 16'(ready), 16'h1);
    chk("wdack.err", 16'(bus_error), 16'h0);
    chk("wdack.data", 16'(data_to_cpu), 16'h0042);
    tick();
`else
    issue(16'hB000, 8'h00, 1'b1);
    for (int i = 0; i < 100; i++) begin
      tick();
      chk("nowd.req_hold", 16'(ext_req), 16'h1);
      chk("nowd.no_rdy", 16'(ready), 16'h0);
    end
    chk("nowd.err", 16'(bus_error), 16'h0);
    ext_ack = 1'b1;
    ext_rdata = 8'h42;
    tick();
    ext_ack = 1'b0;
    tick();
    chk("nowd.rdy", 16'(ready), 16'h1);
    chk("nowd.data", 16'(data_to_cpu), 16'h0042);
    tick();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
